// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer: FSM states, coin values, credit width.
package vend_pkg;

  localparam int unsigned CREDIT_W    = 4;
  localparam int unsigned NICKLE_VAL  = 1;
  localparam int unsigned DIME_VAL    = 2;
  localparam int unsigned QUARTER_VAL = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2,
    FAULT  = 2'd3
  } state_t;

endpackage

// File: rtl/vend_timer.sv
// Acknowledge watchdog: counts cycles while enabled, restarts on clear and flags
// expiry once the wait has spanned ACK_TIMEOUT cycles.
module vend_timer #(
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_expired;

  // Saturating count; expiry is raised as the count lands on the last wait cycle
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clear) begin
      w_cnt_nxt = '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_expired <= (w_cnt_nxt == LAST);
    end
  end

  assign o_expired = r_expired;

endmodule

// File: rtl/vend_sequencer.sv
// Soda vending sequencer: coin crediting, dispense handshake, nickel change payout, ack timeout.
// Optional VEND_REFUND_EN enables the refund request path in IDLE.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned PRICE       = 4,
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_nickle,
  input  logic                i_dime,
  input  logic                i_quarter,
  input  logic                i_refund,
  input  logic                i_soda_ack,
  input  logic                i_nickle_ack,
  output logic                o_soda_req,
  output logic                o_nickle_req,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_busy,
  output logic                o_reject,
  output logic                o_vend_done,
  output logic                o_fault
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic [CREDIT_W-1:0] r_change, w_change_nxt;
  logic                r_soda_req, r_nickle_req, r_busy, r_reject, r_vend_done, r_fault;
  logic                w_reject_nxt, w_vend_done_nxt, w_fault_nxt;
  logic                w_coin_any, w_coin_multi;
  logic [CREDIT_W-1:0] w_coin_val, w_sum;
  logic                w_tmr_clear, w_tmr_enable, w_tmr_expired;

`ifdef VEND_REFUND_EN
  logic r_refund_pend, w_refund_pend_nxt, w_refund_req;
  assign w_refund_req = i_refund | r_refund_pend;
`else
  logic w_unused_refund;
  assign w_unused_refund = i_refund;
`endif

  // Only the highest-value coin of a simultaneous group is credited
  always_comb begin
    w_coin_val = '0;
    if (i_quarter) begin
      w_coin_val = CREDIT_W'(QUARTER_VAL);
    end else if (i_dime) begin
      w_coin_val = CREDIT_W'(DIME_VAL);
    end else if (i_nickle) begin
      w_coin_val = CREDIT_W'(NICKLE_VAL);
    end
  end

  assign w_coin_any   = i_nickle | i_dime | i_quarter;
  assign w_coin_multi = (i_nickle & i_dime) | (i_nickle & i_quarter) | (i_dime & i_quarter);
  assign w_sum        = r_credit + w_coin_val;
  assign w_tmr_enable = (r_state == VEND) || (r_state == CHANGE);

  vend_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_tmr_clear),
    .i_enable  (w_tmr_enable),
    .o_expired (w_tmr_expired)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_credit_nxt    = r_credit;
    w_change_nxt    = r_change;
    w_reject_nxt    = 1'b0;
    w_vend_done_nxt = 1'b0;
    w_fault_nxt     = r_fault;
    w_tmr_clear     = 1'b0;
`ifdef VEND_REFUND_EN
    w_refund_pend_nxt = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        w_tmr_clear = 1'b1;
        if (w_coin_any) begin
          w_credit_nxt = w_sum;
          w_reject_nxt = w_coin_multi;
          if (w_sum >= PRICE_C) begin
            w_state_nxt = VEND;
          end
`ifdef VEND_REFUND_EN
          else begin
            // Coin wins this cycle; the refund of the new total follows next cycle
            w_refund_pend_nxt = w_refund_req;
          end
`endif
        end
`ifdef VEND_REFUND_EN
        else if (w_refund_req && (r_credit != '0)) begin
          w_change_nxt = r_credit;
          w_credit_nxt = '0;
          w_state_nxt  = CHANGE;
        end
`endif
      end

      VEND: begin
        w_reject_nxt = w_coin_any;
        if (i_soda_ack) begin
          w_tmr_clear  = 1'b1;
          w_change_nxt = r_credit - PRICE_C;
          w_credit_nxt = '0;
          if (r_credit == PRICE_C) begin
            w_state_nxt     = IDLE;
            w_vend_done_nxt = 1'b1;
          end else begin
            w_state_nxt = CHANGE;
          end
        end else if (w_tmr_expired) begin
          w_state_nxt = FAULT;
          w_fault_nxt = 1'b1;
        end
      end

      CHANGE: begin
        w_reject_nxt = w_coin_any;
        if (i_nickle_ack) begin
          w_tmr_clear  = 1'b1;
          w_change_nxt = r_change - CREDIT_W'(1);
          if (r_change <= CREDIT_W'(1)) begin
            w_state_nxt     = IDLE;
            w_vend_done_nxt = 1'b1;
          end
        end else if (w_tmr_expired) begin
          w_state_nxt = FAULT;
          w_fault_nxt = 1'b1;
        end
      end

      FAULT: begin
        w_reject_nxt = w_coin_any;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_credit     <= '0;
      r_change     <= '0;
      r_soda_req   <= 1'b0;
      r_nickle_req <= 1'b0;
      r_busy       <= 1'b0;
      r_reject     <= 1'b0;
      r_vend_done  <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_credit     <= w_credit_nxt;
      r_change     <= w_change_nxt;
      r_soda_req   <= (w_state_nxt == VEND);
      r_nickle_req <= (w_state_nxt == CHANGE);
      r_busy       <= (w_state_nxt != IDLE);
      r_reject     <= w_reject_nxt;
      r_vend_done  <= w_vend_done_nxt;
      r_fault      <= w_fault_nxt;
    end
  end

`ifdef VEND_REFUND_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_refund_pend <= 1'b0;
    end else begin
      r_refund_pend <= w_refund_pend_nxt;
    end
  end
`endif

  assign o_soda_req   = r_soda_req;
  assign o_nickle_req = r_nickle_req;
  assign o_credit     = r_credit;
  assign o_busy       = r_busy;
  assign o_reject     = r_reject;
  assign o_vend_done  = r_vend_done;
  assign o_fault      = r_fault;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer (PRICE=4, ACK_TIMEOUT=16); VEND_REFUND_EN selects the refund checks.
module tb_vend_sequencer;

  localparam int unsigned PRICE = 4;
  localparam int unsigned TMO   = 16;

  logic       clk = 1'b0;
  logic       i_rst, i_nickle, i_dime, i_quarter, i_refund, i_soda_ack, i_nickle_ack;
  logic       o_soda_req, o_nickle_req, o_busy, o_reject, o_vend_done, o_fault;
  logic [3:0] o_credit;

  int n_vec = 0;
  int n_err = 0;

  vend_sequencer #(.PRICE(PRICE), .ACK_TIMEOUT(TMO)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_nickle     (i_nickle),
    .i_dime       (i_dime),
    .i_quarter    (i_quarter),
    .i_refund     (i_refund),
    .i_soda_ack   (i_soda_ack),
    .i_nickle_ack (i_nickle_ack),
    .o_soda_req   (o_soda_req),
    .o_nickle_req (o_nickle_req),
    .o_credit     (o_credit),
    .o_busy       (o_busy),
    .o_reject     (o_reject),
    .o_vend_done  (o_vend_done),
    .o_fault      (o_fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given single-cycle pulses applied
  task automatic cyc(input logic n, input logic d, input logic q,
                     input logic r, input logic sa, input logic na);
    i_nickle = n; i_dime = d; i_quarter = q; i_refund = r; i_soda_ack = sa; i_nickle_ack = na;
    step();
    i_nickle = 0; i_dime = 0; i_quarter = 0; i_refund = 0; i_soda_ack = 0; i_nickle_ack = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".credit"}, 32'(o_credit), 0);
    chk({tag, ".soda"},   32'(o_soda_req), 0);
    chk({tag, ".nickle"}, 32'(o_nickle_req), 0);
    chk({tag, ".busy"},   32'(o_busy), 0);
    chk({tag, ".reject"}, 32'(o_reject), 0);
    chk({tag, ".done"},   32'(o_vend_done), 0);
    chk({tag, ".fault"},  32'(o_fault), 0);
  endtask

  initial begin
    i_rst = 1; i_nickle = 0; i_dime = 0; i_quarter = 0;
    i_refund = 0; i_soda_ack = 0; i_nickle_ack = 0;
    step(); step();
    chk_idle_zero("reset");
    i_rst = 0;

    // Two dimes reach the price exactly
    cyc(0, 1, 0, 0, 0, 0);
    chk("dime1.credit", 32'(o_credit), 2);
    chk("dime1.soda", 32'(o_soda_req), 0);
    chk("dime1.busy", 32'(o_busy), 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("dime2.credit", 32'(o_credit), 4);
    chk("dime2.soda", 32'(o_soda_req), 1);
    chk("dime2.busy", 32'(o_busy), 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("exact.done", 32'(o_vend_done), 1);
    chk("exact.credit", 32'(o_credit), 0);
    chk("exact.nickle", 32'(o_nickle_req), 0);
    chk("exact.soda", 32'(o_soda_req), 0);
    chk("exact.busy", 32'(o_busy), 0);
    step();
    chk("exact.done_drop", 32'(o_vend_done), 0);

    // Credit 3 plus quarter -> 8, change of 4 nickels
    cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
    chk("chg.credit3", 32'(o_credit), 3);
    cyc(0, 0, 1, 0, 0, 0);
    chk("chg.credit8", 32'(o_credit), 8);
    chk("chg.soda", 32'(o_soda_req), 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("chg.nreq", 32'(o_nickle_req), 1);
    chk("chg.credit0", 32'(o_credit), 0);
    chk("chg.soda_off", 32'(o_soda_req), 0);
    chk("chg.no_done", 32'(o_vend_done), 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("chg.stray_sack", 32'(o_nickle_req), 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 0, 0, 0, 1);
      chk("chg.nreq_i", 32'(o_nickle_req), (i < 4) ? 1 : 0);
      chk("chg.done_i", 32'(o_vend_done), (i < 4) ? 0 : 1);
    end
    chk("chg.idle", 32'(o_busy), 0);

    // Nickel + quarter together -> only the quarter counts
    step();
    cyc(1, 0, 1, 0, 0, 0);
    chk("multi.credit", 32'(o_credit), 5);
    chk("multi.soda", 32'(o_soda_req), 1);
    chk("multi.reject", 32'(o_reject), 1);
    step();
    chk("multi.reject_drop", 32'(o_reject), 0);

    // Dime during VEND is rejected
    cyc(0, 1, 0, 0, 0, 0);
    chk("vcoin.reject", 32'(o_reject), 1);
    chk("vcoin.credit", 32'(o_credit), 5);
    chk("vcoin.soda", 32'(o_soda_req), 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("vcoin.nreq", 32'(o_nickle_req), 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("vcoin.done", 32'(o_vend_done), 1);
    chk("vcoin.nreq_off", 32'(o_nickle_req), 0);

    // Soda ack never arrives
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("tmo.soda", 32'(o_soda_req), 1);
    repeat (TMO - 1) step();
    chk("tmo.not_yet", 32'(o_fault), 0);
    chk("tmo.soda_held", 32'(o_soda_req), 1);
    step();
    chk("tmo.fault", 32'(o_fault), 1);
    chk("tmo.soda_off", 32'(o_soda_req), 0);
    chk("tmo.nreq_off", 32'(o_nickle_req), 0);
    chk("tmo.busy", 32'(o_busy), 1);
    cyc(1, 0, 0, 0, 1, 0);
    chk("fault.reject", 32'(o_reject), 1);
    chk("fault.sticky", 32'(o_fault), 1);
    i_rst = 1; i_quarter = 1;
    step();
    chk_idle_zero("rst_prio");
    i_rst = 0; i_quarter = 0;
    step();
    chk("rst.fault_clear", 32'(o_fault), 0);

    // An accepted nickel ack restarts the timeout window
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("rstrt.credit", 32'(o_credit), 6);
    cyc(0, 0, 0, 0, 1, 0);
    chk("rstrt.nreq", 32'(o_nickle_req), 1);
    repeat (TMO - 2) step();
    cyc(0, 0, 0, 0, 0, 1);
    chk("rstrt.ack1_fault", 32'(o_fault), 0);
    chk("rstrt.ack1_nreq", 32'(o_nickle_req), 1);
    repeat (TMO - 1) step();
    chk("rstrt.window_fault", 32'(o_fault), 0);
    chk("rstrt.window_nreq", 32'(o_nickle_req), 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rstrt.done", 32'(o_vend_done), 1);
    chk("rstrt.no_fault", 32'(o_fault), 0);

    // Reset mid-VEND abandons without completion
    cyc(0, 0, 1, 0, 0, 0);
    chk("abort.soda", 32'(o_soda_req), 1);
    i_rst = 1;
    step();
    i_rst = 0;
    chk_idle_zero("abort");
    step();
    chk("abort.no_done", 32'(o_vend_done), 0);

    // Refund request with credit 3
    cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
    chk("rfd.credit3", 32'(o_credit), 3);
    cyc(0, 0, 0, 1, 0, 0);
`ifdef VEND_REFUND_EN
    chk("rfd.nreq", 32'(o_nickle_req), 1);
    chk("rfd.credit0", 32'(o_credit), 0);
    chk("rfd.busy", 32'(o_busy), 1);
    for (int i = 1; i <= 3; i++) begin
      chk("rfd.soda_never", 32'(o_soda_req), 0);
      cyc(0, 0, 0, 0, 0, 1);
      chk("rfd.nreq_i", 32'(o_nickle_req), (i < 3) ? 1 : 0);
      chk("rfd.done_i", 32'(o_vend_done), (i < 3) ? 0 : 1);
    end
    chk("rfd.soda_end", 32'(o_soda_req), 0);
    // Coin and refund together: credit first, refund next cycle
    cyc(1, 0, 0, 1, 0, 0);
    chk("rfdc.credit1", 32'(o_credit), 1);
    chk("rfdc.nreq_wait", 32'(o_nickle_req), 0);
    step();
    chk("rfdc.credit0", 32'(o_credit), 0);
    chk("rfdc.nreq", 32'(o_nickle_req), 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rfdc.done", 32'(o_vend_done), 1);
    chk("rfdc.nreq_off", 32'(o_nickle_req), 0);
`else
    chk("norfd.credit", 32'(o_credit), 3);
    chk("norfd.nreq", 32'(o_nickle_req), 0);
    chk("norfd.busy", 32'(o_busy), 0);
    step();
    chk("norfd.credit_hold", 32'(o_credit), 3);
    chk("norfd.no_done", 32'(o_vend_done), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 SHALL have parameter PRICE, default 4, meaning soda price in nickel units (legal range 1..10).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 1000, meaning the maximum number of cycles to wait for any dispenser acknowledge.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have ports i_nickle, i_dime, i_quarter, input, 1 each, single-cycle coin pulses.
REQ-006 SHALL have port i_refund, input, 1, refund request pulse.
REQ-007 SHALL have port i_soda_ack, input, 1, soda dispenser done pulse.
REQ-008 SHALL have port i_nickle_ack, input, 1, change hopper "one nickel paid" pulse.
REQ-009 SHALL have port o_soda_req, output, 1, level request to the soda dispenser.
REQ-010 SHALL have port o_nickle_req, output, 1, level request to the hopper for one nickel.
REQ-011 SHALL have port o_credit, output, 4, accumulated credit in nickels.
REQ-012 SHALL have port o_busy, output, 1, high when coins are not accepted.
REQ-013 SHALL have port o_reject, output, 1, one-cycle pulse marking a coin that was not credited.
REQ-014 SHALL have port o_vend_done, output, 1, one-cycle pulse at transaction end.
REQ-015 SHALL have port o_fault, output, 1, sticky timeout flag.

Function
REQ-016 Coin values SHALL be nickle=1, dime=2, quarter=5 nickel units.
REQ-017 The state machine SHALL have states IDLE, VEND, CHANGE and FAULT; o_busy SHALL be high in every state except IDLE.
REQ-018 In IDLE, an accepted coin at edge N SHALL update o_credit at N+1.
REQ-019 If the new credit is at least PRICE, the block SHALL enter VEND at N+1 with o_soda_req high.
REQ-020 If more than one coin pulse occurs in the same cycle, the block SHALL credit only the highest-value coin and pulse o_reject for one cycle.
REQ-021 Any coin pulse outside IDLE SHALL not change the credit and SHALL pulse o_reject at the next cycle.
REQ-022 In VEND, o_soda_req SHALL hold high until i_soda_ack.
REQ-023 On i_soda_ack, the block SHALL compute change = credit - PRICE and clear o_credit to 0.
REQ-024 On i_soda_ack with change = 0, the block SHALL go to IDLE and pulse o_vend_done in the same transition.
REQ-025 On i_soda_ack with change > 0, the block SHALL go to CHANGE with o_nickle_req high.
REQ-026 In CHANGE, each i_nickle_ack SHALL decrement the change count by 1, with o_nickle_req kept high while the count is above 0.
REQ-027 When the change count reaches 0 in CHANGE, the block SHALL drop o_nickle_req, pulse o_vend_done and return to IDLE.
REQ-028 An acknowledge arriving in a state that does not expect it SHALL be ignored.
REQ-029 The cycle count in VEND or CHANGE SHALL restart at each state entry and at each accepted ack.
REQ-030 If the count reaches ACK_TIMEOUT, the block SHALL enter FAULT: o_fault=1, requests low, o_busy=1.
REQ-031 FAULT SHALL be left only by reset.
REQ-032 The maximum credit SHALL be PRICE-1+5, which must fit in 4 bits; arithmetic SHALL be unsigned with no wrap.

Reset
REQ-033 While i_rst is high at a rising edge, the block SHALL go to IDLE and set credit=0, change=0, timer=0.
REQ-034 During reset, all outputs SHALL be 0: o_soda_req, o_nickle_req, o_busy, o_reject, o_vend_done, o_fault.
REQ-035 Reset asserted mid-VEND or mid-CHANGE SHALL abandon the transaction with no o_vend_done pulse.
REQ-036 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-037 Macro VEND_REFUND_EN defined: i_refund in IDLE with credit>0 SHALL load change=credit, clear credit and enter CHANGE with no soda request.
REQ-038 With VEND_REFUND_EN defined, i_refund in the same cycle as a coin SHALL credit the coin first, then refund the total on the following cycle.
REQ-039 Macro VEND_REFUND_EN undefined: the i_refund port SHALL remain and SHALL be ignored.

Structure
REQ-040 Package vend_pkg SHALL hold the state enum, the coin value constants (NICKLE_VAL, DIME_VAL, QUARTER_VAL) and the credit width constant.
REQ-041 The timeout counter SHALL be a sub-module named vend_timer, with inputs clear and enable and output expired.

Verification
REQ-042 Reset, then pulse i_dime twice -> o_credit=2, then 4; o_soda_req=1 the cycle after the second dime; after i_soda_ack: o_vend_done pulse, o_credit=0, no nickle request.
REQ-043 With credit 3, pulse i_quarter -> o_soda_req; after i_soda_ack, o_nickle_req held for exactly 4 i_nickle_ack pulses, then o_vend_done and IDLE.
REQ-044 Pulse i_nickle and i_quarter in the same cycle from credit 0 -> credit 5, VEND entered, one o_reject pulse.
REQ-045 Pulse i_dime while in VEND -> o_reject pulse, credit unchanged, still VEND.
REQ-046 Hold i_soda_ack low for ACK_TIMEOUT cycles -> o_fault=1 and requests low; assert i_rst -> all outputs 0, IDLE.
REQ-047 With VEND_REFUND_EN, credit 3, pulse i_refund -> 3 nickle payouts, o_vend_done, o_soda_req never high; without the macro, the same stimulus leaves credit 3.
